// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one full-subtractor step per clock; optional SERIAL_SUB_OVERFLOW_EN adds a signed overflow flag.
// Latency: out_valid rises WIDTH+1 edges after the accepting edge; holds result in DONE until out_ready, no queuing while busy.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
`ifdef SERIAL_SUB_OVERFLOW_EN
   ,
   output logic             overflow
`endif
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH);

   logic [1:0]       state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [CW-1:0]    cnt;
   logic             br;
   logic             ai;
   logic             bi;
   logic             d;
   logic             br_nxt;

`ifdef SERIAL_SUB_OVERFLOW_EN
   logic a_msb;
   logic b_msb;
`endif

   assign ai     = a_sr[0];
   assign bi     = b_sr[0];
   assign d      = ai ^ bi ^ br;
   assign br_nxt = (~ai & bi) | (~(ai ^ bi) & br);

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         a_sr   <= '0;
         b_sr   <= '0;
         cnt    <= '0;
         br     <= 1'b0;
         diff   <= '0;
         borrow <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
         overflow <= 1'b0;
         a_msb    <= 1'b0;
         b_msb    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sr  <= a;
                  b_sr  <= b;
                  br    <= 1'b0;
                  cnt   <= '0;
                  state <= RUN;
`ifdef SERIAL_SUB_OVERFLOW_EN
                  overflow <= 1'b0;
                  a_msb    <= a[WIDTH-1];
                  b_msb    <= b[WIDTH-1];
`endif
               end
            end
            RUN: begin
               // Counter stops at WIDTH; that last RUN cycle only publishes the flags.
               if (cnt != LAST) begin
                  diff <= {d, diff[WIDTH-1:1]};
                  a_sr <= a_sr >> 1;
                  b_sr <= b_sr >> 1;
                  br   <= br_nxt;
                  cnt  <= cnt + CW'(1);
               end else begin
                  borrow <= br;
`ifdef SERIAL_SUB_OVERFLOW_EN
                  overflow <= (a_msb != b_msb) & (diff[WIDTH-1] != a_msb);
`endif
                  state <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized checks of serial_subtractor (WIDTH=8) against an arithmetic reference.
module tb_serial_subtractor;

   logic       clk;
   logic       reset;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a;
   logic [7:0] b;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] diff;
   logic       borrow;
`ifdef SERIAL_SUB_OVERFLOW_EN
   logic       overflow;
`endif

   int tests;
   int fails;
   int cyc;

   serial_subtractor #(.WIDTH(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .borrow    (borrow)
`ifdef SERIAL_SUB_OVERFLOW_EN
      ,
      .overflow  (overflow)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] ref_diff(input logic [7:0] x, input logic [7:0] y);
      int r;
      r = (int'(x) - int'(y) + 256) % 256;
      return 8'(r);
   endfunction

   function automatic logic ref_ovf(input logic [7:0] x, input logic [7:0] y);
      int r;
      r = int'($signed(x)) - int'($signed(y));
      return (r > 127) || (r < -128);
   endfunction

   function automatic logic cur_ovf();
`ifdef SERIAL_SUB_OVERFLOW_EN
      return overflow;
`else
      return 1'b0;
`endif
   endfunction

   // One operation; rnd_rdy=1 randomizes out_ready while the result is held.
   task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input bit rnd_rdy,
                         output logic [7:0] od, output logic ob, output logic oo,
                         output int lat, output int acc);
      int guard;
      @(negedge clk);
      a = ta; b = tb_; in_valid = 1'b1;
      guard = 0;
      while (!in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      acc = cyc;
      a = 8'($urandom);
      b = 8'($urandom);
      if (!rnd_rdy) out_ready = 1'b1;
      lat = 0;
      while (!out_valid && lat < 40) begin
         if (rnd_rdy) out_ready = 1'($urandom);
         @(negedge clk);
         lat++;
      end
      od = diff; ob = borrow; oo = cur_ovf();
      if (rnd_rdy) begin
         guard = 0;
         while (out_valid && guard < 100) begin
            out_ready = 1'($urandom);
            @(negedge clk);
            guard++;
            if (out_valid) check("hold_diff", 32'(diff), 32'(od));
         end
      end
   endtask

   logic [7:0] rd;
   logic       rb;
   logic       ro;
   int         rl;
   int         racc;
   int         prev_acc;
   bit         saw_valid;
   logic [7:0] ra;
   logic [7:0] rbv;

   initial begin
      tests = 0; fails = 0;
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_diff", 32'(diff), 32'd0);
      check("rst_borrow", 32'(borrow), 32'd0);
      check("rst_ovf", 32'(cur_ovf()), 32'd0);

      run_op(8'h05, 8'h03, 1'b0, rd, rb, ro, rl, racc);
      check("t1_diff", 32'(rd), 32'h02);
      check("t1_borrow", 32'(rb), 32'd0);
      check("t1_latency", 32'(rl), 32'd9);
      @(negedge clk);
      check("t1_done_1cyc", 32'(out_valid), 32'd0);
      check("t1_in_ready", 32'(in_ready), 32'd1);

      run_op(8'h03, 8'h05, 1'b0, rd, rb, ro, rl, racc);
      check("t2a_diff", 32'(rd), 32'hFE);
      check("t2a_borrow", 32'(rb), 32'd1);
      run_op(8'h00, 8'h01, 1'b0, rd, rb, ro, rl, racc);
      check("t2b_diff", 32'(rd), 32'hFF);
      check("t2b_borrow", 32'(rb), 32'd1);
      run_op(8'h77, 8'h77, 1'b0, rd, rb, ro, rl, racc);
      check("t2c_diff", 32'(rd), 32'h00);
      check("t2c_borrow", 32'(rb), 32'd0);

      run_op(8'h80, 8'h01, 1'b0, rd, rb, ro, rl, racc);
      check("t3a_diff", 32'(rd), 32'h7F);
      check("t3a_borrow", 32'(rb), 32'd0);
`ifdef SERIAL_SUB_OVERFLOW_EN
      check("t3a_ovf", 32'(ro), 32'd1);
`endif
      run_op(8'h7F, 8'h01, 1'b0, rd, rb, ro, rl, racc);
      check("t3b_diff", 32'(rd), 32'h7E);
      check("t3b_ovf", 32'(ro), 32'd0);

      // Backpressure in DONE plus in_valid noise while busy.
      @(negedge clk);
      out_ready = 1'b0;
      a = 8'h40; b = 8'h0F; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 12; i++) begin
         in_valid = 1'($urandom);
         a = 8'($urandom); b = 8'($urandom);
         @(negedge clk);
      end
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("t4_out_valid", 32'(out_valid), 32'd1);
         check("t4_diff", 32'(diff), 32'h31);
         check("t4_in_ready", 32'(in_ready), 32'd0);
         @(negedge clk);
      end
      check("t4_borrow", 32'(borrow), 32'd0);
      out_ready = 1'b1;
      @(negedge clk);
      check("t4_release", 32'(out_valid), 32'd0);
      check("t4_idle", 32'(in_ready), 32'd1);

      // Reset during RUN aborts the operation.
      a = 8'h10; b = 8'h01; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("t5_in_ready", 32'(in_ready), 32'd1);
      check("t5_out_valid", 32'(out_valid), 32'd0);
      check("t5_diff", 32'(diff), 32'd0);
      saw_valid = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (out_valid) saw_valid = 1'b1;
         @(negedge clk);
      end
      check("t5_no_pulse", 32'(saw_valid), 32'd0);
      run_op(8'h10, 8'h01, 1'b0, rd, rb, ro, rl, racc);
      check("t5_diff_after", 32'(rd), 32'h0F);

      prev_acc = -100;
      for (int n = 0; n < 1000; n++) begin
         ra  = 8'($urandom);
         rbv = 8'($urandom);
         if (n % 50 == 0) rbv = ra;
         run_op(ra, rbv, 1'b1, rd, rb, ro, rl, racc);
         check("rnd_diff", 32'(rd), 32'(ref_diff(ra, rbv)));
         check("rnd_borrow", 32'(rb), 32'(ra < rbv));
`ifdef SERIAL_SUB_OVERFLOW_EN
         check("rnd_ovf", 32'(ro), 32'(ref_ovf(ra, rbv)));
`endif
         check("rnd_spacing", 32'(racc - prev_acc >= 10), 32'd1);
         prev_acc = racc;
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
